// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the single memory port: data has priority, a streak
// counter bounds how long a pending fetch can be starved, flush cancels a fetch response.
module mem_arbiter #(
  parameter int MAX_DATA_BURST = 4,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32
) (
  input  logic              clk,
  input  logic              rst_async,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] rdata,
  input  logic              flush,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D} state_e;

  localparam logic [3:0] BURST_MAX = 4'(MAX_DATA_BURST);

  state_e     state_q;
  logic [3:0] streak_q;
  logic       cancel_q;

  logic if_req_eff;
  logic burst_full;
  logic pick_d;
  logic pick_if;

  // A flushed fetch request is not a contender, so it neither wins nor counts toward the streak.
  assign if_req_eff = if_req & ~flush;
  assign burst_full = (streak_q == BURST_MAX);
  assign pick_d     = d_req & ~(if_req_eff & burst_full);
  assign pick_if    = if_req_eff & ~pick_d;

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      state_q   <= IDLE;
      streak_q  <= '0;
      cancel_q  <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_gnt    <= 1'b0;
      d_gnt     <= 1'b0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      rdata     <= '0;
    end else begin
      if_gnt    <= 1'b0;
      d_gnt     <= 1'b0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_d) begin
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            d_gnt     <= 1'b1;
            cancel_q  <= 1'b0;
            state_q   <= BUSY_D;
            if (!if_req_eff) begin
              streak_q <= '0;
            end else if (!burst_full) begin
              streak_q <= streak_q + 4'd1;
            end
          end else if (pick_if) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            if_gnt    <= 1'b1;
            cancel_q  <= flush;
            streak_q  <= '0;
            state_q   <= BUSY_IF;
          end
        end
        BUSY_IF: begin
          if (mem_ack) begin
            mem_req  <= 1'b0;
            cancel_q <= 1'b0;
            state_q  <= IDLE;
            // A flush arriving on the ack edge itself still cancels the response.
            if (!(cancel_q || flush)) begin
              rdata     <= mem_rdata;
              if_rvalid <= 1'b1;
            end
          end else if (flush) begin
            cancel_q <= 1'b1;
          end
        end
        BUSY_D: begin
          if (mem_ack) begin
            mem_req  <= 1'b0;
            d_rvalid <= 1'b1;
            state_q  <= IDLE;
            if (!mem_we) begin
              rdata <= mem_rdata;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
